// File: rtl/alarm_bank.sv
// alarm_bank: N-channel alarm engine driving the buzzer from timestamp matches
module alarm_bank #(
    parameter int N_ALARMS      = 4,
    parameter int STAMP_W       = 64,
    parameter int ON_CYCLES     = 25_000_000,
    parameter int PERIOD_CYCLES = 100_000_000,
    parameter int SNOOZE_SEC    = 300,
    parameter int TIMEOUT_SEC   = 60,
    parameter int DAY_SEC       = 86400,
    parameter int IDX_W         = N_ALARMS > 1 ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sec_tick,
    input  logic [STAMP_W-1:0]  counter,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [STAMP_W-1:0]  wr_stamp,
    input  logic                wr_enable,
    input  logic                wr_daily,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [STAMP_W-1:0]  rd_stamp,
    output logic                rd_enable,
    input  logic                cancel,
    input  logic                snooze,
    output logic                ring,
    output logic                ring_active,
    output logic [IDX_W-1:0]    ring_idx,
    output logic [N_ALARMS-1:0] pending
);
    localparam int BW = PERIOD_CYCLES > 1 ? $clog2(PERIOD_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_SEC + 1);
    localparam int SW = $clog2(SNOOZE_SEC + 1);
    localparam logic [IDX_W:0] N_L = (IDX_W + 1)'(N_ALARMS);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

    state_t state, state_d;
    logic [STAMP_W-1:0]  stamp [N_ALARMS];
    logic [N_ALARMS-1:0] enable, daily, match, clr;
    logic [BW-1:0]       beep_cnt, beep_d, beep_nx;
    logic [TW-1:0]       to_cnt, to_d;
    logic [SW-1:0]       snz_cnt, snz_d;
    logic [IDX_W-1:0]    idx_d, low;
    logic                ring_d;

    // A write to a channel in its match cycle masks that channel's match
    always_comb begin
        match = '0;
        for (int i = 0; i < N_ALARMS; i++)
            match[i] = sec_tick && enable[i] && counter == stamp[i] && !(wr_en && wr_idx == IDX_W'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ALARMS; i++) stamp[i] <= '0;
            enable <= '0;
            daily  <= '0;
        end else begin
            for (int i = 0; i < N_ALARMS; i++) begin
                if (wr_en && wr_idx == IDX_W'(i)) begin
                    stamp[i]  <= wr_stamp;
                    enable[i] <= wr_enable;
                    daily[i]  <= wr_daily;
                end else if (match[i]) begin
                    if (daily[i]) stamp[i] <= stamp[i] + STAMP_W'(DAY_SEC);
                    else enable[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        low = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--)
            if (pending[i]) low = IDX_W'(i);
    end

    assign beep_nx = beep_cnt == BW'(PERIOD_CYCLES - 1) ? '0 : beep_cnt + 1'b1;

    always_comb begin
        state_d = state;
        idx_d   = ring_idx;
        beep_d  = beep_cnt;
        to_d    = to_cnt;
        snz_d   = snz_cnt;
        ring_d  = 1'b0;
        clr     = '0;
        case (state)
            IDLE: if (|pending) begin
                state_d = RINGING;
                idx_d   = low;
                clr     = N_ALARMS'(1) << low;
                beep_d  = '0;
                to_d    = '0;
                ring_d  = 1'b1;
            end
            RINGING: begin
                if (cancel) state_d = IDLE;
                else if (snooze) begin
                    state_d = SNOOZED;
                    snz_d   = SW'(SNOOZE_SEC);
                end else if (sec_tick && to_cnt == TW'(TIMEOUT_SEC - 1)) state_d = IDLE;
                else begin
                    beep_d = beep_nx;
                    ring_d = beep_nx < BW'(ON_CYCLES);
                    to_d   = sec_tick ? to_cnt + 1'b1 : to_cnt;
                end
            end
            SNOOZED: begin
                if (cancel) state_d = IDLE;
                else if (sec_tick && snz_cnt == SW'(1)) begin
                    state_d = RINGING;
                    beep_d  = '0;
                    to_d    = '0;
                    ring_d  = 1'b1;
                end else if (sec_tick) snz_d = snz_cnt - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ring      <= 1'b0;
            ring_idx  <= '0;
            pending   <= '0;
            beep_cnt  <= '0;
            to_cnt    <= '0;
            snz_cnt   <= '0;
            rd_stamp  <= '0;
            rd_enable <= 1'b0;
        end else begin
            state     <= state_d;
            ring      <= ring_d;
            ring_idx  <= idx_d;
            pending   <= (pending & ~clr) | match;
            beep_cnt  <= beep_d;
            to_cnt    <= to_d;
            snz_cnt   <= snz_d;
            rd_stamp  <= {1'b0, rd_idx} < N_L ? stamp[rd_idx] : '0;
            rd_enable <= {1'b0, rd_idx} < N_L ? enable[rd_idx] : 1'b0;
        end
    end

    assign ring_active = state != IDLE;
endmodule
